// File: rtl/memory_arbiter.sv
// ============================================================================
//  memory_arbiter
//  Shares one memory port between fetch (F) and data (D) with NONSEQ/SEQ
//  transfer codes, 2-cycle response routing and a fetch anti-starvation run.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module memory_arbiter #(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic        f_priv,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_abort,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_write,
    input  logic [31:0] d_wdata,
    input  logic        d_size,
    input  logic        d_priv,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_abort,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        abort,
    output logic        write,
    output logic        size,
    output logic [1:0]  prot,
    output logic [1:0]  trans
);

    localparam int              C_CNT_W    = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);
    localparam logic [C_CNT_W-1:0] C_RUN_MAX = C_CNT_W'(MAX_DATA_RUN);
    localparam logic [1:0]      C_OWN_NONE = 2'd0;
    localparam logic [1:0]      C_OWN_F    = 2'd1;
    localparam logic [1:0]      C_OWN_D    = 2'd2;
    localparam logic [1:0]      C_IDLE     = 2'b00;
    localparam logic [1:0]      C_NONSEQ   = 2'b10;
    localparam logic [1:0]      C_SEQ      = 2'b11;

    logic [C_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               write_q, write_d;
    logic               size_q, size_d;
    logic [1:0]         prot_q, prot_d;
    logic [1:0]         trans_q, trans_d;
    logic [1:0]         last_owner_q, last_owner_d;
    logic [31:0]        last_addr_q, last_addr_d;
    logic               p1_valid_q, p1_valid_d;
    logic               p1_is_d_q, p1_is_d_d;
    logic               p2_valid_q, p2_valid_d;
    logic               p2_is_d_q, p2_is_d_d;
    logic [31:0]        f_rdata_q, f_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;

    logic [1:0]         w_win_owner;
    logic [31:0]        w_win_addr;
    logic               w_any_gnt;
    logic               w_seq;

    // Data wins conflicts until it has taken MAX_DATA_RUN grants in a row
    // against a waiting fetch; the counter saturates, so >= is the force point.
    always_comb begin
        f_gnt = f_req && (!d_req || (run_cnt_q >= C_RUN_MAX));
        d_gnt = d_req && !f_gnt;
    end

    always_comb begin
        w_any_gnt   = f_gnt || d_gnt;
        w_win_owner = d_gnt ? C_OWN_D : C_OWN_F;
        w_win_addr  = d_gnt ? d_addr : f_addr;
        w_seq       = (w_win_owner == last_owner_q) &&
                      (w_win_addr == last_addr_q + 32'd1) &&
                      (trans_q != C_IDLE);

        run_cnt_d = run_cnt_q;
        if (!f_req || f_gnt) begin
            run_cnt_d = '0;
        end else if (d_gnt && (run_cnt_q < C_RUN_MAX)) begin
            run_cnt_d = run_cnt_q + C_CNT_W'(1);
        end

        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        prot_d       = prot_q;
        write_d      = 1'b0;
        trans_d      = C_IDLE;
        last_owner_d = C_OWN_NONE;
        last_addr_d  = last_addr_q;
        if (d_gnt) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            write_d = d_write;
            size_d  = d_size;
            prot_d  = {d_priv, 1'b1};
        end else if (f_gnt) begin
            addr_d  = f_addr;
            size_d  = 1'b1;
            prot_d  = {f_priv, 1'b0};
        end
        if (w_any_gnt) begin
            trans_d      = w_seq ? C_SEQ : C_NONSEQ;
            last_owner_d = w_win_owner;
            last_addr_d  = w_win_addr;
        end

        p1_valid_d = w_any_gnt;
        p1_is_d_d  = d_gnt;
        p2_valid_d = p1_valid_q;
        p2_is_d_d  = p1_is_d_q;

        f_rdata_d = f_rdata;
        d_rdata_d = d_rdata;
    end

    // Responses follow the owner two stages down the pipeline; the idle side
    // keeps presenting the last data it was given.
    always_comb begin
        f_rvalid = p2_valid_q && !p2_is_d_q;
        d_rvalid = p2_valid_q && p2_is_d_q;
        f_rdata  = f_rvalid ? rdata : f_rdata_q;
        d_rdata  = d_rvalid ? rdata : d_rdata_q;
        f_abort  = f_rvalid && abort;
        d_abort  = d_rvalid && abort;
        addr     = addr_q;
        wdata    = wdata_q;
        write    = write_q;
        size     = size_q;
        prot     = prot_q;
        trans    = trans_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            run_cnt_q    <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            size_q       <= 1'b0;
            prot_q       <= '0;
            trans_q      <= C_IDLE;
            last_owner_q <= C_OWN_NONE;
            last_addr_q  <= '0;
            p1_valid_q   <= 1'b0;
            p1_is_d_q    <= 1'b0;
            p2_valid_q   <= 1'b0;
            p2_is_d_q    <= 1'b0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            run_cnt_q    <= run_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            size_q       <= size_d;
            prot_q       <= prot_d;
            trans_q      <= trans_d;
            last_owner_q <= last_owner_d;
            last_addr_q  <= last_addr_d;
            p1_valid_q   <= p1_valid_d;
            p1_is_d_q    <= p1_is_d_d;
            p2_valid_q   <= p2_valid_d;
            p2_is_d_q    <= p2_is_d_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
//  tb_memory_arbiter
//  Directed bench for memory_arbiter with a registered-response memory model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_arbiter;

    logic        clk;
    logic        n_reset;
    logic        f_req, f_priv, f_gnt, f_rvalid, f_abort;
    logic [31:0] f_addr, f_rdata;
    logic        d_req, d_write, d_size, d_priv, d_gnt, d_rvalid, d_abort;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] addr, wdata, rdata;
    logic        abort, write, size;
    logic [1:0]  prot, trans;

    logic [31:0] mem [512];
    logic [31:0] mem_rdata;
    logic        ld_en;
    logic [8:0]  ld_addr;
    logic [31:0] ld_data;

    int errors = 0;
    int checks = 0;

    memory_arbiter #(.MAX_DATA_RUN(4)) dut (
        .clk(clk), .n_reset(n_reset),
        .f_req(f_req), .f_addr(f_addr), .f_priv(f_priv), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_abort(f_abort),
        .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata),
        .d_size(d_size), .d_priv(d_priv), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_abort(d_abort),
        .addr(addr), .wdata(wdata), .rdata(rdata), .abort(abort),
        .write(write), .size(size), .prot(prot), .trans(trans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory samples the bus at the end of the bus cycle and answers next cycle.
    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (trans[1]) begin
            if (write) mem[addr[8:0]] <= wdata;
            mem_rdata <= mem[addr[8:0]];
        end
    end
    assign rdata = mem_rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [8:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_reset = 1'b0;
        f_req = 0; f_addr = '0; f_priv = 0;
        d_req = 0; d_addr = '0; d_write = 0; d_wdata = '0; d_size = 0; d_priv = 0;
        abort = 0; ld_en = 0; ld_addr = '0; ld_data = '0;

        load(9'h010, 32'hE3A00001);
        load(9'h011, 32'hE3A01002);
        load(9'h012, 32'hE0800001);
        load(9'h013, 32'hEAFFFFFE);
        load(9'h020, 32'h12345678);
        load(9'h000, 32'hA5A5A5A5);
        load(9'h1FF, 32'h5A5A5A5A);

        @(negedge clk);
        check("reset_trans", trans, 0);
        check("reset_write", write, 0);
        check("reset_addr", addr, 0);
        check("reset_size", size, 0);
        check("reset_f_rvalid", f_rvalid, 0);
        check("reset_d_rvalid", d_rvalid, 0);
        tick(); n_reset = 1'b1;
        tick();

        // Single fetch
        tick(); f_req = 1; f_addr = 32'h10;
        @(negedge clk);
        check("single_f_gnt", f_gnt, 1);
        check("single_d_gnt", d_gnt, 0);
        tick(); f_req = 0;
        @(negedge clk);
        check("single_trans", trans, 2'b10);
        check("single_addr", addr, 32'h10);
        check("single_prot", prot, 2'b00);
        tick();
        @(negedge clk);
        check("single_f_rvalid", f_rvalid, 1);
        check("single_f_rdata", f_rdata, 32'hE3A00001);
        check("single_d_rvalid", d_rvalid, 0);

        // Sequential burst, then a gap
        tick(); f_req = 1; f_addr = 32'h10;
        tick(); f_addr = 32'h11;
        @(negedge clk);
        check("burst_trans0", trans, 2'b10);
        tick(); f_addr = 32'h12;
        @(negedge clk);
        check("burst_trans1", trans, 2'b11);
        check("burst_rvalid0", f_rvalid, 1);
        check("burst_rdata0", f_rdata, 32'hE3A00001);
        tick(); f_req = 0;
        @(negedge clk);
        check("burst_trans2", trans, 2'b11);
        check("burst_addr2", addr, 32'h12);
        check("burst_rvalid1", f_rvalid, 1);
        check("burst_rdata1", f_rdata, 32'hE3A01002);
        tick(); f_req = 1; f_addr = 32'h13;
        @(negedge clk);
        check("gap_trans", trans, 2'b00);
        check("burst_rvalid2", f_rvalid, 1);
        check("burst_rdata2", f_rdata, 32'hE0800001);
        tick(); f_req = 0;
        @(negedge clk);
        check("after_gap_trans", trans, 2'b10);
        check("after_gap_addr", addr, 32'h13);
        check("after_gap_no_rvalid", f_rvalid, 0);
        tick();
        @(negedge clk);
        check("after_gap_rdata", f_rdata, 32'hEAFFFFFE);

        // Conflict: D write and F read together
        tick();
        d_req = 1; d_write = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_size = 0; d_priv = 0;
        f_req = 1; f_addr = 32'h20; f_priv = 1;
        @(negedge clk);
        check("conflict_d_gnt", d_gnt, 1);
        check("conflict_f_gnt", f_gnt, 0);
        tick(); d_req = 0; d_write = 0;
        @(negedge clk);
        check("conflict_f_gnt_next", f_gnt, 1);
        check("conflict_d_gnt_next", d_gnt, 0);
        check("conflict_bus_write", write, 1);
        check("conflict_bus_prot", prot, 2'b01);
        check("conflict_bus_trans", trans, 2'b10);
        check("conflict_bus_addr", addr, 32'h100);
        check("conflict_bus_wdata", wdata, 32'hDEADBEEF);
        check("conflict_bus_size", size, 0);
        tick(); f_req = 0; f_priv = 0;
        @(negedge clk);
        check("fetch_bus_write", write, 0);
        check("fetch_bus_prot", prot, 2'b10);
        check("fetch_bus_trans", trans, 2'b10);
        check("fetch_bus_addr", addr, 32'h20);
        check("fetch_bus_size", size, 1);
        check("fetch_wdata_hold", wdata, 32'hDEADBEEF);
        check("write_d_rvalid", d_rvalid, 1);
        check("write_f_rvalid", f_rvalid, 0);
        tick();
        @(negedge clk);
        check("conflict_f_rvalid", f_rvalid, 1);
        check("conflict_f_rdata", f_rdata, 32'h12345678);
        check("conflict_d_rvalid_low", d_rvalid, 0);

        // D read-back with abort on its response cycle
        tick(); d_req = 1; d_addr = 32'h100; d_write = 0;
        @(negedge clk);
        check("dread_d_gnt", d_gnt, 1);
        tick(); d_req = 0;
        @(negedge clk);
        check("dread_trans", trans, 2'b10);
        check("dread_write", write, 0);
        check("dread_prot", prot, 2'b01);
        tick(); abort = 1;
        @(negedge clk);
        check("dread_rvalid", d_rvalid, 1);
        check("dread_rdata", d_rdata, 32'hDEADBEEF);
        check("abort_d_abort", d_abort, 1);
        check("abort_f_abort", f_abort, 0);
        check("abort_f_rvalid", f_rvalid, 0);
        check("abort_f_rdata_hold", f_rdata, 32'h12345678);
        tick(); abort = 0;
        @(negedge clk);
        check("post_abort_d_abort", d_abort, 0);
        check("post_abort_d_rvalid", d_rvalid, 0);
        check("d_rdata_hold", d_rdata, 32'hDEADBEEF);

        // Starvation: both requesting continuously
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                f_req = 1; f_addr = 32'h20;
                d_req = 1; d_addr = 32'h100; d_write = 0;
            end
            @(negedge clk);
            check($sformatf("starve_gnt%0d", i), {f_gnt, d_gnt}, ((i % 5) == 4) ? 2'b10 : 2'b01);
        end
        tick(); f_req = 0; d_req = 0;
        tick(); tick(); tick();

        // Address wrap counts as sequential
        tick(); f_req = 1; f_addr = 32'hFFFFFFFF;
        tick(); f_addr = 32'h0;
        @(negedge clk);
        check("wrap_trans0", trans, 2'b10);
        check("wrap_addr0", addr, 32'hFFFFFFFF);
        tick(); f_req = 0;
        @(negedge clk);
        check("wrap_trans1", trans, 2'b11);
        check("wrap_addr1", addr, 32'h0);
        check("wrap_rdata0", f_rdata, 32'h5A5A5A5A);
        tick();
        @(negedge clk);
        check("wrap_rdata1", f_rdata, 32'hA5A5A5A5);
        tick();

        // Reset with two transfers in flight
        tick(); f_req = 1; f_addr = 32'h10;
        tick(); f_addr = 32'h11;
        tick(); f_req = 0; n_reset = 0;
        #1;
        check("midrst_trans", trans, 0);
        check("midrst_addr", addr, 0);
        check("midrst_write", write, 0);
        check("midrst_prot", prot, 0);
        check("midrst_f_rvalid", f_rvalid, 0);
        check("midrst_f_rdata", f_rdata, 0);
        tick(); n_reset = 1;
        @(negedge clk);
        check("post_rst_f_rvalid0", f_rvalid, 0);
        tick();
        @(negedge clk);
        check("post_rst_f_rvalid1", f_rvalid, 0);
        check("post_rst_d_rvalid1", d_rvalid, 0);
        tick(); f_req = 1; f_addr = 32'h11;
        @(negedge clk);
        check("post_rst_f_gnt", f_gnt, 1);
        tick(); f_req = 0;
        @(negedge clk);
        check("post_rst_trans", trans, 2'b10);
        check("post_rst_addr", addr, 32'h11);
        tick();
        @(negedge clk);
        check("post_rst_f_rvalid", f_rvalid, 1);
        check("post_rst_f_rdata", f_rdata, 32'hE3A01002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single memory_controller port between the instruction fetch path (port F) and the load/store data path (port D) of processor.
- Accepts at most one access per cycle and drives registered addr/wdata/write/size/prot/trans to memory.
- Generates AHB-style NONSEQ/SEQ transfer codes and routes each response (rdata/abort) back to the requester that issued it.
- Data has priority; a run counter prevents fetch starvation.

Parameters:
- MAX_DATA_RUN, 4, number of consecutive D grants allowed while F is waiting before F is forced through; 0 means F wins every conflict.

Ports:
- clk  in  1  clock
- n_reset  in  1  asynchronous active-low reset
- f_req  in  1  fetch request (always a read)
- f_addr  in  32  fetch word address
- f_priv  in  1  fetch privileged
- f_gnt  out  1  fetch accepted this cycle (combinational)
- f_rvalid  out  1  fetch response valid
- f_rdata  out  32  fetch read data
- f_abort  out  1  fetch abort
- d_req  in  1  data request
- d_addr  in  32  data word address
- d_write  in  1  1 = write
- d_wdata  in  32  write data
- d_size  in  1  transfer size
- d_priv  in  1  data privileged
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  data response valid (reads and writes)
- d_rdata  out  32  data read data
- d_abort  out  1  data abort
- addr  out  32  memory address
- wdata  out  32  memory write data
- rdata  in  32  memory read data
- abort  in  1  memory abort
- write  out  1  memory write
- size  out  1  memory size
- prot  out  2  {priv, is_data}
- trans  out  2  00 IDLE, 10 NONSEQ, 11 SEQ

Behaviour:
- Reset (async, n_reset=0) clears all registered outputs to 0 (trans=00, write=0, addr=0), clears the in-flight pipeline, sets run_cnt=0 and last_owner=NONE.
- Arbitration is combinational in cycle N:
  - D only -> d_gnt.
  - F only -> f_gnt.
  - Both, with run_cnt < MAX_DATA_RUN -> d_gnt.
  - Both, with run_cnt == MAX_DATA_RUN -> f_gnt.
  - f_gnt and d_gnt are never both high.
  - Requesters hold req and attributes until gnt; a new request may be presented in the cycle after gnt.
- run_cnt:
  - Increments on a D grant while f_req=1.
  - Clears on an F grant or whenever f_req=0.
  - Saturates at MAX_DATA_RUN.
- Bus stage, at posedge ending cycle N with a grant:
  - addr/wdata/write/size are taken from the winner.
  - For F: write=0, size=1, wdata holds its previous value.
  - prot = {priv, owner==D}.
  - trans = 11 if the owner equals last_owner, addr == last_addr+1 (32-bit wrap, FFFFFFFF->0 counts as sequential) and the previous bus cycle was not IDLE; otherwise trans = 10.
  - last_owner and last_addr are updated.
- No grant: trans=00, write=0, addr/wdata/size/prot hold, last_owner=NONE.
- Response:
  - Memory performs the access at the posedge ending N+1; the response is in cycle N+2.
  - A 2-deep shift register of {valid, owner} tracks in-flight transfers; throughput is one per cycle, latency is 2 cycles from gnt to rvalid.
  - In cycle N+2 the owner's x_rvalid=1, x_rdata=rdata and x_abort=abort.
  - The non-owner's rvalid/abort are 0; its rdata holds its last value.
  - rvalid is also asserted for writes, with rdata undefined-but-stable.
- Reset mid-operation discards in-flight entries: no rvalid is issued for pre-reset grants after release, and the first post-reset transfer is NONSEQ.

Test Plan:
- Single fetch: f_req, f_addr=0x10, memory[0x10]=0xE3A00001. Expect f_gnt in cycle 0, trans=10 with addr=0x10 in cycle 1, and f_rvalid=1 with f_rdata=0xE3A00001 in cycle 2.
- Sequential burst: fetch 0x10, 0x11, 0x12 back-to-back. Expect trans 10, 11, 11 and three consecutive f_rvalid. After a 1-cycle gap, fetch 0x13 gives trans=10.
- Conflict: d_req write 0x100=0xDEADBEEF and f_req 0x20 in the same cycle. Expect d_gnt=1 and f_gnt=0, then f_gnt next cycle. The bus shows write=1, prot=x1, trans=10, then write=0, prot=x0, trans=10. A later D read of 0x100 returns 0xDEADBEEF.
- Starvation: MAX_DATA_RUN=4, both requesting continuously. Expect grant sequence D,D,D,D,F,D,D,D,D,F.
- Abort routing: abort=1 during a D read's response cycle. Expect d_rvalid=1 and d_abort=1, with f_abort=0 and f_rvalid=0.
- Reset mid-operation: pulse n_reset low with two transfers in flight. Expect all outputs 0 immediately, no rvalid after release, and the next grant to 0x11 shows trans=10.
